biriscv_decode_queue: RTL and testbench
=======================================

Name: biriscv_decode_queue

Overview:
- Instruction queue between the 64-bit fetch stage and the dual-issue decode/issue stage.
- Buffers 64-bit fetch packets (two 32-bit instruction words each) and masks invalid halves (mid-packet branch target, predicted-taken lower slot, faults).
- Presents up to two oldest valid instructions per cycle, in program order, possibly spanning two packets.
- Fully flushed on pipeline redirect.

Parameters:
- DEPTH, 4: packet entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- flush_i  in  1  discard all queued and incoming packets (branch/redirect)
- in_valid_i  in  1  fetch packet valid
- in_instr_i  in  64  [31:0]=word at pc+0, [63:32]=word at pc+4
- in_pc_i  in  32  packet PC; bits[1:0] ignored; bit2 = start half
- in_pred_i  in  2  bit n set = word n predicted-taken branch
- in_fault_fetch_i  in  1  bus error on packet
- in_fault_page_i  in  1  page fault on packet
- in_accept_o  out  1  queue can take a packet this cycle
- out0_valid_o  out  1  oldest instruction valid
- out0_instr_o  out  32  instruction word
- out0_pc_o  out  32  word PC ({pc[31:3],half,2'b0})
- out0_pred_o  out  1  predicted taken
- out0_fault_fetch_o  out  1  fetch fault
- out0_fault_page_o  out  1  page fault
- out1_valid_o, out1_instr_o, out1_pc_o, out1_pred_o, out1_fault_fetch_o, out1_fault_page_o  out  1/32/32/1/1/1  next-oldest instruction
- out0_accept_i  in  1  consumer takes slot 0
- out1_accept_i  in  1  consumer takes slot 1; honoured only with out0_accept_i

Behaviour:
- Reset: all entries invalid, wr/rd pointers and count 0, all out*_valid_o=0, all out data 0, in_accept_o=1.
- in_accept_o = (count != DEPTH), from registered count only; no same-cycle push-on-pop when full.
- Push when in_valid_i & in_accept_o & !flush_i. Per-packet mask computed at write:
  - lo = !pc[2]
  - hi = !(lo & in_pred_i[0])
  - any fault: mask = only the first valid half (lo if !pc[2], else hi); fault flags stored with it.
  - mask==0 never occurs; entry always written.
- Output ordering:
  - out0 = lowest set half of head entry.
  - out1 = next set half after out0: hi of head if set, else lowest set half of head+1 if count≥2, else invalid.
  - out1 forced invalid when out0 carries a fault (fault serialises).
- Data on invalid slots is 0. Outputs are combinational from registered state; no combinational path from in_* to out_* (zero-bypass: 1-cycle min latency push→out0_valid_o).
- Pop: out0_accept_i clears out0's mask bit; out0_accept_i & out1_accept_i also clears out1's bit. Accept on an invalid slot is ignored. out1_accept_i without out0_accept_i is ignored.
- Retire: an entry whose mask reaches 0 advances rd pointer. Up to 2 entries can retire per cycle (out0 hi of head, out1 lo of head+1 with head+1 also emptied).
- Count update = pushes − retires, same cycle; pointers wrap modulo DEPTH.
- flush_i: next cycle all masks 0, pointers/count 0. Overrides push and pop in the same cycle. Outputs remain valid during the flush cycle itself; consumer ignores them.
- rst_i mid-operation: identical to flush plus output clear; takes priority over all.

Decomposition:
- Shared defs header: packet field offsets (word width 32, packet width 64), entry field layout (instr 64, pc[31:3], pred 2, mask 2, faults 2).
- No sub-module. Storage is a flop array inline, since the mask bits are read-modify-written per cycle.

Test Plan:
- Reset, then push pc=0x1000, instr={0x00200093,0x00100013}, pred=0; next cycle out0 pc=0x1000 instr=0x00100013, out1 pc=0x1004 instr=0x00200093; accept both → queue empty, in_accept_o=1.
- Push pc=0x2004 (mid-packet) then pc=0x2008; out0 pc=0x2004, out1 pc=0x2008 (spanning); accept out0 only → out0 pc=0x2008, out1 pc=0x200C.
- Push pc=0x3000, pred=2'b01 → out0 pc=0x3000 pred=1, out1 from next packet (0x3004 dropped).
- Fill DEPTH=4 packets without accepts → in_accept_o=0 after the 4th. Push attempted while full with simultaneous out accept → not taken. Following cycle in_accept_o=1.
- Push faulting packet pc=0x4000 with fault_page=1 behind a good packet → good packet drains; then out0 pc=0x4000 fault_page=1, out1_valid_o=0.
- Queue with 3 entries, assert flush_i together with in_valid_i and out accepts → next cycle all valid=0, count=0; incoming packet discarded.

Source files
------------

// File: rtl/biriscv_decode_queue_pkg.sv
// rtl/biriscv_decode_queue_pkg.sv - shared field layout for the decode queue
package biriscv_decode_queue_pkg;

  localparam int WORD_W  = 32;
  localparam int PKT_W   = 64;
  localparam int PC_HI_W = 29;

  typedef struct packed {
    logic [PKT_W-1:0]   instr;
    logic [PC_HI_W-1:0] pc_hi;
    logic [1:0]         pred;
    logic [1:0]         mask;
    logic               fault_fetch;
    logic               fault_page;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instr;
    logic [31:0]       pc;
    logic              pred;
    logic              fault_fetch;
    logic              fault_page;
  } slot_t;

  // A faulting packet keeps only its first live half so the fault issues alone.
  function automatic logic [1:0] entry_mask(input logic pc2, input logic pred0,
                                            input logic fault);
    logic lo;
    logic hi;
    lo = !pc2;
    hi = !(lo && pred0);
    if (fault) return lo ? 2'b01 : 2'b10;
    return {hi, lo};
  endfunction

  function automatic slot_t make_slot(input entry_t e, input logic half);
    slot_t s;
    s.valid       = 1'b1;
    s.instr       = half ? e.instr[PKT_W-1:WORD_W] : e.instr[WORD_W-1:0];
    s.pc          = {e.pc_hi, half, 2'b00};
    s.pred        = e.pred[half];
    s.fault_fetch = e.fault_fetch;
    s.fault_page  = e.fault_page;
    return s;
  endfunction

endpackage

// File: rtl/biriscv_decode_queue.sv
// rtl/biriscv_decode_queue.sv - fetch packet queue presenting two in-order instructions
module biriscv_decode_queue
  import biriscv_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [63:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  input  logic [1:0]  in_pred_i,
  input  logic        in_fault_fetch_i,
  input  logic        in_fault_page_i,
  output logic        in_accept_o,
  output logic        out0_valid_o,
  output logic [31:0] out0_instr_o,
  output logic [31:0] out0_pc_o,
  output logic        out0_pred_o,
  output logic        out0_fault_fetch_o,
  output logic        out0_fault_page_o,
  output logic        out1_valid_o,
  output logic [31:0] out1_instr_o,
  output logic [31:0] out1_pc_o,
  output logic        out1_pred_o,
  output logic        out1_fault_fetch_o,
  output logic        out1_fault_page_o,
  input  logic        out0_accept_i,
  input  logic        out1_accept_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             entries_q [DEPTH];
  entry_t             entries_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [PTR_W-1:0]   nxt_ptr;
  entry_t             head, nxt;
  logic               s0_valid, s0_half, s0_fault;
  logic               s1_head, s1_next, s1_valid, s1_half;
  slot_t              slot0, slot1;
  logic               push, pop0, pop1, retire0, retire1;
  logic [1:0]         head_mask_n, nxt_mask_n, retire_n;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^in_pc_i[1:0];
  assign in_accept_o    = (count_q != CNT_W'(DEPTH));

  always_comb begin
    nxt_ptr  = rd_ptr_q + PTR_W'(1);
    head     = entries_q[rd_ptr_q];
    nxt      = entries_q[nxt_ptr];
    s0_valid = (count_q != '0);
    s0_half  = ~head.mask[0];
    s0_fault = head.fault_fetch | head.fault_page;
    s1_head  = !s0_half && head.mask[1];
    s1_next  = !s1_head && (count_q >= CNT_W'(2));
    s1_valid = s0_valid && !s0_fault && (s1_head || s1_next);
    s1_half  = s1_head ? 1'b1 : ~nxt.mask[0];
    slot0    = s0_valid ? make_slot(head, s0_half) : '0;
    slot1    = s1_valid ? make_slot(s1_head ? head : nxt, s1_half) : '0;
  end

  assign out0_valid_o       = slot0.valid;
  assign out0_instr_o       = slot0.instr;
  assign out0_pc_o          = slot0.pc;
  assign out0_pred_o        = slot0.pred;
  assign out0_fault_fetch_o = slot0.fault_fetch;
  assign out0_fault_page_o  = slot0.fault_page;
  assign out1_valid_o       = slot1.valid;
  assign out1_instr_o       = slot1.instr;
  assign out1_pc_o          = slot1.pc;
  assign out1_pred_o        = slot1.pred;
  assign out1_fault_fetch_o = slot1.fault_fetch;
  assign out1_fault_page_o  = slot1.fault_page;

  always_comb begin
    entries_d   = entries_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_mask_n = head.mask;
    nxt_mask_n  = nxt.mask;
    pop0        = out0_accept_i && s0_valid;
    pop1        = pop0 && out1_accept_i && s1_valid;
    push        = in_valid_i && in_accept_o;

    if (pop0) head_mask_n[s0_half] = 1'b0;
    if (pop1) begin
      if (s1_head) head_mask_n[1] = 1'b0;
      else         nxt_mask_n[s1_half] = 1'b0;
    end
    if (s0_valid) entries_d[rd_ptr_q].mask = head_mask_n;
    if (pop1 && !s1_head) entries_d[nxt_ptr].mask = nxt_mask_n;

    // The second entry can only empty when out1 drew from it and the head emptied too.
    retire0  = s0_valid && (head_mask_n == 2'b00);
    retire1  = retire0 && pop1 && !s1_head && (nxt_mask_n == 2'b00);
    retire_n = {1'b0, retire0} + {1'b0, retire1};
    rd_ptr_d = rd_ptr_q + PTR_W'(retire_n);

    if (push) begin
      entries_d[wr_ptr_q].instr       = in_instr_i;
      entries_d[wr_ptr_q].pc_hi       = in_pc_i[31:3];
      entries_d[wr_ptr_q].pred        = in_pred_i;
      entries_d[wr_ptr_q].mask        = entry_mask(in_pc_i[2], in_pred_i[0],
                                                   in_fault_fetch_i | in_fault_page_i);
      entries_d[wr_ptr_q].fault_fetch = in_fault_fetch_i;
      entries_d[wr_ptr_q].fault_page  = in_fault_page_i;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(retire_n);

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].mask = 2'b00;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_biriscv_decode_queue.sv
// tb/tb_biriscv_decode_queue.sv - directed self-checking bench for the decode queue
module tb_biriscv_decode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [1:0]  in_pred = '0;
  logic        in_ff = 1'b0;
  logic        in_fp = 1'b0;
  logic        in_accept;
  logic        o0_valid, o0_pred, o0_ff, o0_fp;
  logic [31:0] o0_instr, o0_pc;
  logic        o1_valid, o1_pred, o1_ff, o1_fp;
  logic [31:0] o1_instr, o1_pc;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  biriscv_decode_queue #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_instr_i(in_instr), .in_pc_i(in_pc), .in_pred_i(in_pred),
    .in_fault_fetch_i(in_ff), .in_fault_page_i(in_fp), .in_accept_o(in_accept),
    .out0_valid_o(o0_valid), .out0_instr_o(o0_instr), .out0_pc_o(o0_pc),
    .out0_pred_o(o0_pred), .out0_fault_fetch_o(o0_ff), .out0_fault_page_o(o0_fp),
    .out1_valid_o(o1_valid), .out1_instr_o(o1_instr), .out1_pc_o(o1_pc),
    .out1_pred_o(o1_pred), .out1_fault_fetch_o(o1_ff), .out1_fault_page_o(o1_fp),
    .out0_accept_i(acc0), .out1_accept_i(acc1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [63:0] instr, input logic [1:0] pred,
                      input logic ff, input logic fp);
    in_valid = 1'b1; in_pc = pc; in_instr = instr; in_pred = pred; in_ff = ff; in_fp = fp;
    tick();
    in_valid = 1'b0; in_pred = '0; in_ff = 1'b0; in_fp = 1'b0;
  endtask

  task automatic accept(input logic a0, input logic a1);
    acc0 = a0; acc1 = a1;
    tick();
    acc0 = 1'b0; acc1 = 1'b0;
  endtask

  // Packets whose words equal their own PCs make expected instr values obvious.
  function automatic logic [63:0] pc_words(input logic [31:0] pc);
    return {pc + 32'd4, pc};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_accept", in_accept, 1);
    check("rst_o0_valid", o0_valid, 0);
    check("rst_o1_valid", o1_valid, 0);
    check("rst_o0_instr", o0_instr, 0);
    check("rst_o1_pc", o1_pc, 0);

    // Basic full packet, with a zero-bypass check before the push edge
    in_valid = 1'b1; in_pc = 32'h1000; in_instr = 64'h00200093_00100013; in_pred = 2'b00;
    #1;
    check("nobypass_o0_valid", o0_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t1_o0_pc", o0_pc, 32'h1000);
    check("t1_o0_instr", o0_instr, 32'h00100013);
    check("t1_o1_valid", o1_valid, 1);
    check("t1_o1_pc", o1_pc, 32'h1004);
    check("t1_o1_instr", o1_instr, 32'h00200093);
    accept(1, 1);
    check("t1_empty", o0_valid, 0);
    check("t1_accept", in_accept, 1);

    // Mid-packet start and spanning across two packets
    push(32'h2004, 64'h22222222_11111111, 2'b00, 0, 0);
    push(32'h2008, 64'h44444444_33333333, 2'b00, 0, 0);
    check("t2_o0_pc", o0_pc, 32'h2004);
    check("t2_o0_instr", o0_instr, 32'h22222222);
    check("t2_o1_pc", o1_pc, 32'h2008);
    check("t2_o1_instr", o1_instr, 32'h33333333);
    accept(1, 0);
    check("t2b_o0_pc", o0_pc, 32'h2008);
    check("t2b_o1_pc", o1_pc, 32'h200C);
    check("t2b_o1_instr", o1_instr, 32'h44444444);
    accept(0, 1);
    check("t2c_o1only_ignored", o0_pc, 32'h2008);
    accept(1, 1);
    check("t2_empty", o0_valid, 0);

    // Predicted-taken lower word drops the upper word
    push(32'h3000, 64'h55555555_66666666, 2'b01, 0, 0);
    push(32'h3008, 64'h88888888_77777777, 2'b00, 0, 0);
    check("t3_o0_pc", o0_pc, 32'h3000);
    check("t3_o0_pred", o0_pred, 1);
    check("t3_o0_instr", o0_instr, 32'h66666666);
    check("t3_o1_pc", o1_pc, 32'h3008);
    check("t3_o1_pred", o1_pred, 0);
    accept(1, 1);
    check("t3b_o0_pc", o0_pc, 32'h300C);
    check("t3b_o1_valid", o1_valid, 0);
    accept(1, 0);
    check("t3_empty", o0_valid, 0);

    // Fill to DEPTH, then a push while full alongside an accept is refused
    for (int i = 0; i < 4; i++) begin
      push(32'h5000 + 32'(i * 8), pc_words(32'h5000 + 32'(i * 8)), 2'b00, 0, 0);
      check($sformatf("t4_accept_%0d", i), in_accept, (i == 3) ? 0 : 1);
    end
    in_valid = 1'b1; in_pc = 32'h6000; in_instr = pc_words(32'h6000);
    accept(1, 1);
    in_valid = 1'b0;
    check("t4_accept_after", in_accept, 1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("t4_drain_o0_%0d", i), o0_pc, 32'h5000 + 32'(i * 8));
      check($sformatf("t4_drain_i1_%0d", i), o1_instr, 32'h5004 + 32'(i * 8));
      accept(1, 1);
    end
    check("t4_empty", o0_valid, 0);

    // Fault serialises behind a good packet
    push(32'h3FF8, pc_words(32'h3FF8), 2'b00, 0, 0);
    push(32'h4000, pc_words(32'h4000), 2'b00, 0, 1);
    check("t5_o0_pc", o0_pc, 32'h3FF8);
    check("t5_o1_pc", o1_pc, 32'h3FFC);
    accept(1, 1);
    check("t5_f_pc", o0_pc, 32'h4000);
    check("t5_f_page", o0_fp, 1);
    check("t5_f_fetch", o0_ff, 0);
    check("t5_f_o1_valid", o1_valid, 0);
    accept(1, 1);
    check("t5_empty", o0_valid, 0);
    push(32'h8004, pc_words(32'h8000), 2'b00, 1, 0);
    check("t5b_pc", o0_pc, 32'h8004);
    check("t5b_fetch", o0_ff, 1);
    check("t5b_o1_valid", o1_valid, 0);
    accept(1, 0);
    check("t5b_empty", o0_valid, 0);

    // Flush with three entries, a concurrent push and accepts
    for (int i = 0; i < 3; i++) push(32'h9000 + 32'(i * 8), pc_words(32'h9000 + 32'(i * 8)), 2'b00, 0, 0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'hA000; in_instr = pc_words(32'hA000);
    #1;
    check("t6_valid_during_flush", o0_valid, 1);
    accept(1, 1);
    flush = 1'b0; in_valid = 1'b0;
    check("t6_o0_valid", o0_valid, 0);
    check("t6_o1_valid", o1_valid, 0);
    check("t6_accept", in_accept, 1);
    tick();
    check("t6_discarded", o0_valid, 0);
    push(32'h7000, pc_words(32'h7000), 2'b00, 0, 0);
    check("t6_restart_pc", o0_pc, 32'h7000);
    check("t6_restart_o1", o1_pc, 32'h7004);

    // Reset mid-operation clears everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_o0_valid", o0_valid, 0);
    check("t7_o0_pc", o0_pc, 0);
    check("t7_accept", in_accept, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
